// File: rtl/alu_sequencer.sv
// Initiator side of the 64-bit ALU port.
// It sequences single ops and an iterative shift-add MUL through the external ALU.
module alu_sequencer #(
    parameter int WIDTH          = 64,
    parameter int MUL_EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [4:0]       alu_fs,
    output logic             alu_c0,
    input  logic [WIDTH-1:0] alu_out,
    input  logic [3:0]       alu_status
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_ORR = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_EOR = 3'b100;
    localparam logic [2:0] OP_LSL = 3'b101;
    localparam logic [2:0] OP_LSR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_p;
    logic [CW-1:0]    r_cnt;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_result;
    logic [3:0]       r_rsp_flags;
    logic             w_mul_done;

    assign req_ready  = (r_state == IDLE) && !rst;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign rsp_flags  = r_rsp_flags;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mul_done  = 1'b0;
        alu_a       = '0;
        alu_b       = '0;
        alu_fs      = 5'b00000;
        alu_c0      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_state_nxt = (req_op == OP_MUL) ? MUL : EXEC;
                end
            end
            EXEC: begin
                alu_a       = r_a;
                alu_b       = r_b;
                w_state_nxt = RESP;
                case (r_op)
                    OP_AND:  alu_fs = 5'b00000;
                    OP_ORR:  alu_fs = 5'b00100;
                    OP_ADD:  alu_fs = 5'b01000;
                    OP_SUB: begin
                        alu_fs = 5'b01001;
                        alu_c0 = 1'b1;
                    end
                    OP_EOR:  alu_fs = 5'b01100;
                    OP_LSL:  alu_fs = 5'b10000;
                    OP_LSR:  alu_fs = 5'b10100;
                    default: alu_fs = 5'b00000;
                endcase
            end
            MUL: begin
                // P accumulates M whenever the current multiplier bit is set
                alu_a      = r_p;
                alu_b      = r_b[0] ? r_a : '0;
                alu_fs     = 5'b01000;
                w_mul_done = (r_cnt == CW'(WIDTH - 1)) ||
                             ((MUL_EARLY_EXIT != 0) && ((r_b >> 1) == '0));
                if (w_mul_done) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_p          <= '0;
            r_cnt        <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_flags  <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_op  <= req_op;
                        r_a   <= req_a;
                        r_b   <= req_b;
                        r_p   <= '0;
                        r_cnt <= '0;
                    end
                end
                EXEC: begin
                    r_rsp_result <= alu_out;
                    r_rsp_flags  <= alu_status;
                    r_rsp_valid  <= 1'b1;
                end
                MUL: begin
                    r_p   <= alu_out;
                    r_a   <= r_a << 1;
                    r_b   <= r_b >> 1;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_mul_done) begin
                        r_rsp_result <= alu_out;
                        r_rsp_flags  <= alu_status;
                        r_rsp_valid  <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
